loader_sequencer: RTL and testbench
===================================

// Module: loader_sequencer
// PURPOSE
//   Sequences the 16-to-32 pattern loader to fill a ROWS-deep grid, one row at a time.
//   Accepts 16-bit seed words on a valid/ready stream and presents each word to the loader.
//   Asserts the loader permit and issues a row write strobe so the grid memory captures the 32-bit expanded row.
//   Sits between the seed source (host/ROM reader) and the loader + grid row memory.
// PARAMETERS
//   ROWS    32  number of grid rows loaded per frame (>=2)
//   HOLD    1   cycles permit is held before the write strobe (>=1); covers loader settle
//   AW      $clog2(ROWS)  row address width (derived, not overridden)
// PORTS
//   clk       in   1     clock, all state on rising edge
//   rst_n     in   1     asynchronous active-low reset
//   start     in   1     pulse: begin a frame load (ignored unless IDLE)
//   abort     in   1     pulse: cancel the current load, return to IDLE
//   in_valid  in   1     seed word valid
//   in_data   in   16    seed word; bit 1 of the loader values = in_data[15]
//   in_ready  out  1     sequencer can take a seed word
//   permit    out  1     loader enable
//   values    out  16    registered seed word driven to the loader
//   row_addr  out  AW    grid row being written
//   row_we    out  1     grid row write strobe (captures loader out[1:32])
//   busy      out  1     high in any state other than IDLE
//   done      out  1     one-cycle pulse after the last row is written
// BEHAVIOUR
//   Reset (async assert, sync release):
//     state=IDLE; all outputs 0; row counter=0; values=0.
//   FSM states: IDLE, ACCEPT, DRIVE, WRITE, FIN.
//   IDLE:
//     in_ready=0, permit=0.
//     start=1 -> ACCEPT, row counter=0.
//   ACCEPT:
//     in_ready=1, permit=0.
//     On in_valid&in_ready: values<=in_data; -> DRIVE.
//     No handshake: stay; values unchanged.
//   DRIVE:
//     permit=1 for HOLD cycles (hold counter), values stable; -> WRITE.
//   WRITE:
//     permit=1, row_we=1 for exactly one cycle, row_addr=row counter.
//     If row counter==ROWS-1 -> FIN; else counter+1, -> ACCEPT.
//   FIN:
//     done=1 for one cycle, permit=0; -> IDLE.
//     row_addr remains ROWS-1 until the next start.
//   Latency:
//     Handshake at cycle t -> permit rises t+1, row_we at t+1+HOLD.
//     Min HOLD+2 cycles per row (one extra ACCEPT cycle), ROWS*(HOLD+2)+1 per frame with in_valid tied high.
//   Handshake rules:
//     in_ready only in ACCEPT; data offered outside ACCEPT is not consumed.
//     in_valid may drop without penalty.
//   Boundaries:
//     start while busy -> ignored, no counter reset.
//     abort in any non-IDLE state -> IDLE next cycle; permit/row_we/in_ready low that cycle; no done.
//     Rows already written stay written.
//     abort wins over start and over a same-cycle handshake; the accepted word is discarded.
//     abort in IDLE -> no effect.
//     Row counter never wraps inside a frame; ROWS-1 is terminal.
//     start and done same cycle impossible (FIN precedes IDLE).
//     Mid-operation rst_n low -> immediate reset values, including permit=0 and row_we=0.
//   values changes only on an ACCEPT handshake.
//   row_we never asserted without permit=1 in the same cycle.
// TESTING
//   1. ROWS=4, HOLD=1, in_valid=1, data 16'hA5A5,16'h0001,16'h8000,16'hFFFF
//      -> row_we at addr 0..3 with those values; done at cycle 13 after start; busy 0 after.
//   2. Stall: in_valid low 5 cycles in ACCEPT
//      -> in_ready held 1, permit 0, no row_we, row counter unchanged, values unchanged.
//   3. abort in the DRIVE of row 2
//      -> IDLE next cycle, no row_we for row 2, no done; next start rewrites from row 0.
//   4. start pulsed during row 1 WRITE -> ignored; frame completes normally with 4 writes.
//   5. rst_n low in WRITE -> row_we/permit/busy drop asynchronously; values=0.
//      After release: IDLE, start required.
//   6. HOLD=3: permit high 4 cycles per row, row_we in the last of them.
//      Assertion: row_we implies permit, across all tests.

Source files
------------

// File: rtl/loader_sequencer_if.sv
// Seed stream plus loader/grid-row bus shared by the sequencer and its surroundings.
// The master side is the sequencer; the slave side is the seed source, loader and row memory.
interface loader_sequencer_if #(
    parameter int unsigned AW = 5
);
    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_ready;
    logic          permit;
    logic [15:0]   values;
    logic [AW-1:0] row_addr;
    logic          row_we;

    modport master (
        input  in_valid, in_data,
        output in_ready, permit, values, row_addr, row_we
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, permit, values, row_addr, row_we
    );
endinterface

// File: rtl/loader_sequencer.sv
// Frame load sequencer: takes one seed word per row, holds the loader permit for HOLD cycles,
// then strobes the grid row write. All outputs come straight from flops.
module loader_sequencer #(
    parameter int unsigned ROWS = 32,
    parameter int unsigned HOLD = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    loader_sequencer_if.master bus,
    output logic               busy,
    output logic               done
);
    localparam int unsigned AW = $clog2(ROWS);
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [2:0] {StIdle, StAccept, StDrive, StWrite, StFin} state_e;

    state_e        state_q;
    logic [AW-1:0] row_q;
    logic [HW-1:0] hold_q;
    logic [15:0]   values_q;
    logic          in_ready_q, permit_q, row_we_q, busy_q, done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            row_q      <= '0;
            hold_q     <= '0;
            values_q   <= '0;
            in_ready_q <= 1'b0;
            permit_q   <= 1'b0;
            row_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            row_we_q <= 1'b0;
            done_q   <= 1'b0;
            // Abort outranks start and any handshake offered in the same cycle.
            if (abort && state_q != StIdle) begin
                state_q    <= StIdle;
                in_ready_q <= 1'b0;
                permit_q   <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q    <= StAccept;
                            row_q      <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    StAccept: begin
                        if (bus.in_valid && in_ready_q) begin
                            values_q   <= bus.in_data;
                            state_q    <= StDrive;
                            in_ready_q <= 1'b0;
                            permit_q   <= 1'b1;
                            hold_q     <= HW'(HOLD - 1);
                        end
                    end
                    StDrive: begin
                        if (hold_q == '0) begin
                            state_q  <= StWrite;
                            row_we_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q - HW'(1);
                        end
                    end
                    StWrite: begin
                        permit_q <= 1'b0;
                        if (row_q == AW'(ROWS - 1)) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                        end else begin
                            row_q      <= row_q + AW'(1);
                            state_q    <= StAccept;
                            in_ready_q <= 1'b1;
                        end
                    end
                    StFin: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.permit   = permit_q;
    assign bus.values   = values_q;
    assign bus.row_addr = row_q;
    assign bus.row_we   = row_we_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_loader_sequencer.sv
// Bench for loader_sequencer: two instances (HOLD=1 and HOLD=3, ROWS=4) driven with random and
// directed frames; expectations come from a per-row timing model computed ahead of each frame.
module tb_loader_sequencer;
    localparam int ROWS = 4;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic busy_a, busy_b, done_a, done_b;
    logic sel = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    loader_sequencer_if #(.AW(2)) ifa ();
    loader_sequencer_if #(.AW(2)) ifb ();
    assign ifa.in_valid = in_valid;
    assign ifa.in_data  = in_data;
    assign ifb.in_valid = in_valid;
    assign ifb.in_data  = in_data;

    loader_sequencer #(.ROWS(ROWS), .HOLD(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .bus(ifa),
        .busy(busy_a), .done(done_a)
    );
    loader_sequencer #(.ROWS(ROWS), .HOLD(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .bus(ifb),
        .busy(busy_b), .done(done_b)
    );

    logic o_ready, o_permit, o_we, o_busy, o_done;
    logic [15:0] o_val;
    logic [1:0] o_addr;
    always_comb begin
        o_ready  = sel ? ifb.in_ready : ifa.in_ready;
        o_permit = sel ? ifb.permit   : ifa.permit;
        o_we     = sel ? ifb.row_we   : ifa.row_we;
        o_val    = sel ? ifb.values   : ifa.values;
        o_addr   = sel ? ifb.row_addr : ifa.row_addr;
        o_busy   = sel ? busy_b       : busy_a;
        o_done   = sel ? done_b       : done_a;
    end

    logic [15:0] tbl [4] = '{16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF};
    logic [15:0] cur_val [2];
    logic [1:0]  cur_addr [2];

    bit          e_ready [MAXC], e_permit [MAXC], e_we [MAXC], e_done [MAXC], e_busy [MAXC];
    bit          hs [MAXC];
    logic [15:0] e_val [MAXC];
    logic [1:0]  e_addr [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                       input int k);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, k, obs, exp);
        end
    endtask

    // Row r: first valid cycle t at/after accept start c is the handshake; permit t+1..t+1+hold,
    // write at t+1+hold, next accept at t+hold+2; done lands on the cycle after the last write.
    task automatic run_frame(input bit s, input int hold, input bit allv, input int stall,
                             input int abort_at, input int xstart_at, input bit use_tbl);
        bit          vld [MAXC];
        logic [15:0] dat [MAXC];
        logic [15:0] cv;
        int c, t, dc, last;
        sel = s;
        for (int k = 0; k < MAXC; k++) begin
            vld[k] = allv || ($urandom_range(0, 3) != 0) || (k >= 150);
            if (k >= 1 && k <= stall) vld[k] = 1'b0;
            dat[k] = 16'($urandom);
            e_ready[k] = 0; e_permit[k] = 0; e_we[k] = 0; e_done[k] = 0; e_busy[k] = 0;
            hs[k] = 0;
            e_addr[k] = cur_addr[s];
        end
        c = 1;
        for (int r = 0; r < ROWS; r++) begin
            t = c;
            while (!vld[t]) t++;
            hs[t] = 1;
            if (use_tbl) dat[t] = tbl[r];
            for (int k = c; k <= t; k++) begin e_ready[k] = 1; e_addr[k] = 2'(r); end
            for (int k = t + 1; k <= t + 1 + hold; k++) begin
                e_permit[k] = 1; e_addr[k] = 2'(r);
            end
            e_we[t + 1 + hold] = 1;
            c = t + hold + 2;
        end
        dc = c;
        e_done[dc] = 1;
        for (int k = 1; k <= dc; k++) e_busy[k] = 1;
        for (int k = dc; k < MAXC; k++) e_addr[k] = 2'(ROWS - 1);
        cv = cur_val[s];
        for (int k = 0; k < MAXC; k++) begin
            e_val[k] = cv;
            if (hs[k]) cv = dat[k];
        end
        last = dc + 2;
        if (abort_at >= 0 && abort_at < dc) begin
            for (int k = abort_at + 1; k < MAXC; k++) begin
                e_ready[k] = 0; e_permit[k] = 0; e_we[k] = 0; e_done[k] = 0; e_busy[k] = 0;
                e_addr[k] = e_addr[abort_at];
                e_val[k]  = e_val[abort_at];
            end
            last = abort_at + 3;
        end
        for (int k = 0; k <= last; k++) begin
            if (s) start_b = (k == 0) || (k == xstart_at);
            else   start_a = (k == 0) || (k == xstart_at);
            abort    = (k == abort_at);
            in_valid = vld[k];
            in_data  = dat[k];
            @(negedge clk);
            chk("in_ready", 32'(o_ready), 32'(e_ready[k]), k);
            chk("permit",   32'(o_permit), 32'(e_permit[k]), k);
            chk("row_we",   32'(o_we), 32'(e_we[k]), k);
            chk("done",     32'(o_done), 32'(e_done[k]), k);
            chk("busy",     32'(o_busy), 32'(e_busy[k]), k);
            chk("values",   32'(o_val), 32'(e_val[k]), k);
            chk("row_addr", 32'(o_addr), 32'(e_addr[k]), k);
            chk("we_implies_permit", 32'(o_we & ~o_permit), 32'(0), k);
            @(posedge clk); #1;
        end
        start_a = 0; start_b = 0; abort = 0; in_valid = 0;
        cur_val[s]  = e_val[last];
        cur_addr[s] = e_addr[last];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        cur_val  = '{16'h0, 16'h0};
        cur_addr = '{2'd0, 2'd0};
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_busy", 32'(o_busy), 32'(0), 0);
            chk("rst_ready", 32'(o_ready), 32'(0), 0);
            chk("rst_permit", 32'(o_permit), 32'(0), 0);
            chk("rst_values", 32'(o_val), 32'(0), 0);
            chk("rst_addr", 32'(o_addr), 32'(0), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(0, 1, 1, 0, -1, -1, 1);          // table data, valid tied high, done at 13
        run_frame(0, 1, 0, 5, -1, -1, 0);          // 5-cycle stall then random valid
        run_frame(0, 1, 1, 0, 8, -1, 0);           // abort in DRIVE of row 2
        run_frame(0, 1, 1, 0, -1, -1, 0);          // restart rewrites from row 0
        run_frame(0, 1, 1, 0, -1, 6, 0);           // start during row 1 WRITE ignored

        // Reset asserted while row 0 is being written.
        sel = 0;
        in_valid = 1; in_data = 16'h1234; start_a = 1;
        @(posedge clk); #1; start_a = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_we", 32'(o_we), 32'(1), 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(o_we), 32'(0), 3);
        chk("async_rst_permit", 32'(o_permit), 32'(0), 3);
        chk("async_rst_busy", 32'(o_busy), 32'(0), 3);
        chk("async_rst_values", 32'(o_val), 32'(0), 3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(o_ready), 32'(0), k);
            chk("post_rst_busy", 32'(o_busy), 32'(0), k);
            @(posedge clk); #1;
        end
        in_valid = 0;
        cur_val  = '{16'h0, 16'h0};
        cur_addr = '{2'd0, 2'd0};

        run_frame(1, 3, 1, 0, -1, -1, 0);          // HOLD=3, valid tied high
        run_frame(1, 3, 0, 3, -1, -1, 0);          // HOLD=3, stall + random valid
        for (int i = 0; i < 6; i++) begin
            run_frame(i[0], i[0] ? 3 : 1, 0, 0, -1, -1, 0);
            run_frame(i[0], i[0] ? 3 : 1, 0, 0, int'($urandom_range(1, 14)), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
